// File: rtl/rep_impl_checker.sv
// rep_impl_checker: synthesizable monitor for the implication
//   a[*N_A] |-> ##DELAY b[*N_B]
// Every overlapping attempt is tracked as one alive bit in a shift pipeline
// indexed by its sample offset from the trigger cycle. Each completed attempt
// produces a registered pass or fail pulse. Saturating pass/fail counters are
// readable by on-chip debug logic.
//
// Optional feature, enabled by defining REP_IMPL_FIRST_FAIL_EN:
//   A free-running 32-bit cycle counter runs. The cycle of the first failing
//   sample is latched on first_fail_cyc/first_fail_vld. When the macro is
//   undefined, both ports are tied to 0 and no counter exists.
module rep_impl_checker #(
  parameter int N_A   = 2,   // consecutive a cycles that fire an attempt (>=1)
  parameter int DELAY = 2,   // trigger cycle to first b sample (>=0)
  parameter int N_B   = 2,   // consecutive b cycles required (>=1)
  parameter int CNT_W = 16   // pass/fail counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy,
  output logic             first_fail_vld,
  output logic [31:0]      first_fail_cyc
);

  // Total number of sample offsets an attempt lives through: 0 .. L-1.
  localparam int L    = DELAY + N_B;
  // a-run counter only needs to reach N_A-1.
  localparam int AR_W = (N_A > 1) ? $clog2(N_A) : 1;
  localparam logic [AR_W-1:0] AR_MAX = AR_W'(N_A - 1);
  // At most N_B attempts can sit inside the b window, so at most N_B fail at once.
  localparam int NF_W = $clog2(N_B + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered state.
  logic [AR_W-1:0]  arun_q,     arun_d;
  logic [L-1:0]     stage_q,    stage_d;   // stage_q[k]: attempt at offset k+1 this cycle
  logic             pass_q,     pass_d;
  logic             fail_q,     fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // Combinational helpers.
  logic                  trig;
  logic [L-1:0]          live;       // live[k]: attempt evaluated at offset k this cycle
  logic [L-1:0]          fail_vec;   // attempts dying on this cycle's b sample
  logic                  pass_hit;
  logic [NF_W-1:0]       nfail;
  logic [CNT_W+NF_W-1:0] fail_sum;

  // A new attempt fires when a has been high with en for N_A cycles in a row.
  assign trig = en & a & ~clr & (arun_q == AR_MAX);

  // Next-state for the a-run counter, attempt pipeline, pulses and counters.
  always_comb begin
    // NOTE: every variable assigned in this block receives a default first, so no path can leave a value held and infer a latch.
    arun_d     = '0;
    live       = '0;
    stage_d    = '0;
    fail_vec   = '0;
    pass_hit   = 1'b0;
    nfail      = '0;
    fail_sum   = '0;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;

    if (en && a) begin
      arun_d = (arun_q == AR_MAX) ? arun_q : arun_q + AR_W'(1);
    end

    // Offset 0 is the trigger cycle itself. Older attempts come from the pipeline.
    live[0] = trig;
    for (int k = 1; k < L; k++) begin
      live[k] = stage_q[k-1];
    end

    for (int k = 0; k < L; k++) begin
      if (k < DELAY) begin
        stage_d[k] = live[k];
      end else if (!b) begin
        fail_vec[k] = live[k];
      end else if (k == L - 1) begin
        pass_hit = live[k];
      end else begin
        stage_d[k] = live[k];
      end
    end

    for (int k = 0; k < L; k++) begin
      nfail = nfail + NF_W'(fail_vec[k]);
    end

    pass_d = pass_hit;
    fail_d = |fail_vec;

    if (pass_hit && (pass_cnt_q != CNT_MAX)) begin
      pass_cnt_d = pass_cnt_q + CNT_W'(1);
    end

    // Add the number of simultaneous failures with headroom, then clamp.
    fail_sum = {{NF_W{1'b0}}, fail_cnt_q} + {{CNT_W{1'b0}}, nfail};
    if (fail_sum > {{NF_W{1'b0}}, CNT_MAX}) begin
      fail_cnt_d = CNT_MAX;
    end else begin
      fail_cnt_d = fail_sum[CNT_W-1:0];
    end
  end

  // State registers. rst discards everything. clr does the same synchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      arun_q     <= '0;
      stage_q    <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else if (clr) begin
      arun_q     <= '0;
      stage_q    <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      arun_q     <= arun_d;
      stage_q    <= stage_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign busy     = |stage_q;

`ifdef REP_IMPL_FIRST_FAIL_EN
  logic [31:0] cyc_q;
  logic        ff_vld_q;
  logic [31:0] ff_cyc_q;

  // Cycle counter, plus a one-shot capture of the cycle of the first failure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= '0;
      ff_vld_q <= 1'b0;
      ff_cyc_q <= '0;
    end else if (clr) begin
      cyc_q    <= '0;
      ff_vld_q <= 1'b0;
      ff_cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (!ff_vld_q && fail_d) begin
        ff_vld_q <= 1'b1;
        ff_cyc_q <= cyc_q;
      end
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_cyc = ff_cyc_q;
`else
  assign first_fail_vld = 1'b0;
  assign first_fail_cyc = '0;
`endif

endmodule

// File: doc/rep_impl_checker.md
Name: rep_impl_checker

Overview:
- Synthesizable RTL monitor for the consecutive-repetition implication "a[*N_A] |-> ##DELAY b[*N_B]".
- Sits directly downstream of the a/b stimulus path and consumes the same two signals an SVA property would sample.
- Tracks every overlapping attempt, emits per-attempt pass/fail pulses and keeps saturating pass/fail counters readable by silicon/FPGA debug logic.

Parameters:
- N_A, 2, consecutive cycles a must be high to fire an attempt (>=1)
- DELAY, 2, cycles from trigger cycle to first b sample (>=0; 0 = overlapping implication)
- N_B, 2, consecutive cycles b must be high (>=1)
- CNT_W, 16, width of pass/fail counters

Ports:
- clk  in  1  clock; all sampling on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = new attempts may fire; 0 = no triggers, a-run counter cleared, pending attempts continue
- clr  in  1  synchronous clear of counters, pending attempts, a-run counter
- a  in  1  antecedent signal
- b  in  1  consequent signal
- pass  out  1  registered pulse, one attempt completed successfully
- fail  out  1  registered pulse, >=1 attempt failed this cycle
- pass_cnt  out  CNT_W  saturating count of passed attempts
- fail_cnt  out  CNT_W  saturating count of failed attempts
- busy  out  1  any attempt pending
- first_fail_vld  out  1  see Optional Feature
- first_fail_cyc  out  32  see Optional Feature

Behaviour:
- Reset (rst=1, async): all outputs 0, a-run counter 0, pending stages 0, cycle counter 0.
- a-run counter: a=1 and en=1 -> increment, saturating at N_A-1; a=0 or en=0 -> 0.
- Trigger at cycle t: en=1, a=1, a-run counter == N_A-1 (N_A=1: a=1 alone). a held for N_A+k cycles -> k+1 triggers, one per cycle (overlapping, SVA semantics).
- Pending pipeline: alive bits stage[0..DELAY+N_B-1]. Trigger enters stage 0. Stage index = sample offset from t.
- Stage k < DELAY: advances unconditionally.
- Stage k in [DELAY, DELAY+N_B-1] (window): b=1 -> advance (last stage -> pass); b=0 -> attempt dies, counted as fail.
- DELAY=0: trigger-cycle b is first window sample.
- pass/fail registered at the posedge sampling the deciding b; pulse visible for exactly the following cycle.
- At most one pass per cycle. Several fails per cycle possible: fail=1 once; fail_cnt += popcount of failing stages, saturating at 2^CNT_W-1.
- pass_cnt += 1 per pass, saturating. Both counters hold at max, no wrap.
- Pass and fail in same cycle (different attempts): both pulses, both counters update.
- busy = OR of all alive stages (registered view).
- clr=1: next posedge zeroes counters, stages, a-run, pulses; no trigger that cycle; rst dominates clr.
- rst mid-attempt: attempts discarded, no pass/fail ever reported for them.

Optional Feature:
- Macro REP_IMPL_FIRST_FAIL_EN.
- Defined: free-running 32-bit cycle counter (wraps, cleared by rst/clr). First fail event latches counter value (cycle of deciding sample) into first_fail_cyc and sets first_fail_vld. Both hold until rst or clr.
- Undefined: ports exist, tied to 0, no counter logic.

Test Plan:
- a=1 at cycles 1,2; b=1 at 4,5 -> pass pulse cycle 6, pass_cnt=1, fail_cnt=0, busy low from cycle 6.
- a=1 at 1,2; b=1 at 4 only -> fail pulse cycle 6, fail_cnt=1, pass_cnt=0. With REP_IMPL_FIRST_FAIL_EN: first_fail_vld=1, first_fail_cyc=5.
- a=1 at 1..3; b=1 at 4..6 -> pass pulses cycles 6 and 7, pass_cnt=2.
- a=1 at 1..3; b=1 at 4,5 -> pass cycle 6, fail cycle 7 (second attempt's b low at 6), counts 1/1.
- a=1 at 1,2; b=1 at 4,5; rst pulsed during cycle 4 -> no pass, counters 0, busy 0 right after rst.
- CNT_W=2, 5 failing attempts -> fail_cnt saturates at 3. en=0 during a=1 at 1..4 -> no trigger, busy stays 0.
